// File: rtl/uart_hex_cmd_rx.sv
// 8N1 UART receiver feeding an ASCII hex line parser: each "0xAAAAAAAA[ 0xDDDDDDDD]\n"
// line becomes one command held on a valid/ack handshake; malformed lines are flagged.
module uart_hex_cmd_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    input  logic        i_cmd_ack,
    output logic        o_cmd_valid,
    output logic        o_cmd_wr,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dataw,
    output logic        o_err,
    output logic        o_overrun
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;

    typedef enum logic [2:0] {RX_WAIT_IDLE, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [3:0] {
        P_IDLE, P_X, P_ADR, P_SEP, P_D0, P_DX, P_DAT, P_EOL, P_SKIP, P_PEND
    } p_state_e;

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, 4'(c[3:0] + 4'd9)};
        else
            return 5'd0;
    endfunction

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             stop_ok_q, stop_ok_d, frame_err_q, frame_err_d, byte_stb_q;

    p_state_e         p_state_q, p_state_d;
    logic [31:0]      adr_sh_q, adr_sh_d, dat_sh_q, dat_sh_d;
    logic [2:0]       dig_q, dig_d;
    logic             drop_q, drop_d;
    logic             cmd_valid_q, cmd_valid_d, cmd_wr_q, cmd_wr_d;
    logic [31:0]      mem_adr_q, mem_adr_d, mem_dataw_q, mem_dataw_d;
    logic             err_q, err_d, ovr_q, ovr_d;
    logic             syn_bad;
    logic [4:0]       hex;
    logic             is_x;

    always_comb begin
        // NOTE: every variable gets its default first, so no path can infer a latch.
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CNT_W'(1);
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        stop_ok_d   = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_WAIT_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    stop_ok_d  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    rx_state_d  = RX_WAIT_IDLE;
                end
            end
            default: rx_state_d = RX_WAIT_IDLE;
        endcase
    end

    assign hex  = hex_decode(rx_sh_q);
    assign is_x = (rx_sh_q == 8'h78) || (rx_sh_q == 8'h58);

    always_comb begin
        p_state_d   = p_state_q;
        adr_sh_d    = adr_sh_q;
        dat_sh_d    = dat_sh_q;
        dig_d       = dig_q;
        drop_d      = drop_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        mem_adr_d   = mem_adr_q;
        mem_dataw_d = mem_dataw_q;
        err_d       = 1'b0;
        ovr_d       = 1'b0;
        syn_bad     = 1'b0;
        if (p_state_q == P_PEND) begin
            if (byte_stb_q)  begin ovr_d = 1'b1; drop_d = 1'b1; end
            if (frame_err_q) begin err_d = 1'b1; drop_d = 1'b1; end
            // A byte dropped in the ack cycle still forces a resync on the next '\n'.
            if (i_cmd_ack) begin
                cmd_valid_d = 1'b0;
                drop_d      = 1'b0;
                p_state_d   = (drop_q || byte_stb_q || frame_err_q) ? P_SKIP : P_IDLE;
            end
        end else if (frame_err_q) begin
            err_d     = 1'b1;
            p_state_d = P_SKIP;
        end else if (byte_stb_q && rx_sh_q != CH_CR) begin
            case (p_state_q)
                P_IDLE: if (rx_sh_q == CH_0) p_state_d = P_X;
                        else if (rx_sh_q != CH_LF) syn_bad = 1'b1;
                P_X:    if (is_x) begin p_state_d = P_ADR; dig_d = '0; end
                        else syn_bad = 1'b1;
                P_ADR:  if (hex[4]) begin
                            adr_sh_d = {adr_sh_q[27:0], hex[3:0]};
                            dig_d    = dig_q + 3'd1;
                            if (dig_q == 3'd7) p_state_d = P_SEP;
                        end else syn_bad = 1'b1;
                P_SEP:  if (rx_sh_q == CH_SP) p_state_d = P_D0;
                        else if (rx_sh_q == CH_LF) begin
                            mem_adr_d   = adr_sh_q;
                            mem_dataw_d = '0;
                            cmd_wr_d    = 1'b0;
                            cmd_valid_d = 1'b1;
                            p_state_d   = P_PEND;
                        end else syn_bad = 1'b1;
                P_D0:   if (rx_sh_q == CH_0) p_state_d = P_DX;
                        else syn_bad = 1'b1;
                P_DX:   if (is_x) begin p_state_d = P_DAT; dig_d = '0; end
                        else syn_bad = 1'b1;
                P_DAT:  if (hex[4]) begin
                            dat_sh_d = {dat_sh_q[27:0], hex[3:0]};
                            dig_d    = dig_q + 3'd1;
                            if (dig_q == 3'd7) p_state_d = P_EOL;
                        end else syn_bad = 1'b1;
                P_EOL:  if (rx_sh_q == CH_LF) begin
                            mem_adr_d   = adr_sh_q;
                            mem_dataw_d = dat_sh_q;
                            cmd_wr_d    = 1'b1;
                            cmd_valid_d = 1'b1;
                            p_state_d   = P_PEND;
                        end else syn_bad = 1'b1;
                P_SKIP: if (rx_sh_q == CH_LF) p_state_d = P_IDLE;
                default: ;
            endcase
            if (syn_bad) begin
                err_d     = 1'b1;
                p_state_d = P_SKIP;
            end
        end
        if (p_state_d == P_IDLE && p_state_q != P_IDLE) begin
            adr_sh_d = '0;
            dat_sh_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // Synchronizer resets low so a line held low through reset never looks like an edge.
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
            rx_prev_q   <= 1'b0;
            rx_state_q  <= RX_WAIT_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            stop_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
            byte_stb_q  <= 1'b0;
            p_state_q   <= P_IDLE;
            adr_sh_q    <= '0;
            dat_sh_q    <= '0;
            dig_q       <= '0;
            drop_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_dataw_q <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            rx_meta_q   <= i_uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            stop_ok_q   <= stop_ok_d;
            frame_err_q <= frame_err_d;
            byte_stb_q  <= stop_ok_q;
            p_state_q   <= p_state_d;
            adr_sh_q    <= adr_sh_d;
            dat_sh_q    <= dat_sh_d;
            dig_q       <= dig_d;
            drop_q      <= drop_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            mem_adr_q   <= mem_adr_d;
            mem_dataw_q <= mem_dataw_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd_wr    = cmd_wr_q;
    assign o_mem_adr   = mem_adr_q;
    assign o_mem_dataw = mem_dataw_q;
    assign o_err       = err_q;
    assign o_overrun   = ovr_q;
endmodule
